// File: rtl/frame_scanner.sv
// Raster-sweeps lookup coordinates, realigns the returned colour, and emits plot writes.
// Optional build macro SKIP_BLACK_EN: suppress plot pulses for pixels whose colour is 3'b000.
module frame_scanner #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int LOOKUP_LAT = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] flag_in,
  output logic [8:0] scan_x,
  output logic [8:0] scan_y,
  output logic [8:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] X_LAST     = 9'(H_RES - 1);
  localparam logic [8:0] Y_LAST     = 9'(V_RES - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(LOOKUP_LAT);

  state_t     state_q, state_d;
  logic [8:0] scan_x_q, scan_x_d;
  logic [8:0] scan_y_q, scan_y_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       plot_q, plot_d;
  logic [8:0] vga_x_q, vga_x_d;
  logic [8:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;

  logic [LOOKUP_LAT-1:0]      dly_vld_q, dly_vld_d;
  logic [LOOKUP_LAT-1:0][8:0] dly_x_q, dly_x_d;
  logic [LOOKUP_LAT-1:0][8:0] dly_y_q, dly_y_d;

  logic       issue_s;
  logic       tap_vld_s;
  logic [8:0] tap_x_s;
  logic [8:0] tap_y_s;
  logic       keep_s;

  // Every SCAN cycle presents one coordinate to the lookup.
  assign issue_s   = (state_q == SCAN);
  assign tap_vld_s = dly_vld_q[LOOKUP_LAT-1];
  assign tap_x_s   = dly_x_q[LOOKUP_LAT-1];
  assign tap_y_s   = dly_y_q[LOOKUP_LAT-1];

  always_comb begin
    state_d       = state_q;
    scan_x_d      = scan_x_q;
    scan_y_d      = scan_y_q;
    drain_cnt_d   = drain_cnt_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        scan_x_d    = 9'd0;
        scan_y_d    = 9'd0;
        drain_cnt_d = 3'd0;
        if (start) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (scan_x_q == X_LAST) begin
          scan_x_d = 9'd0;
          if (scan_y_q == Y_LAST) begin
            scan_y_d    = 9'd0;
            drain_cnt_d = 3'd0;
            state_d     = DRAIN;
          end else begin
            scan_y_d = scan_y_q + 9'd1;
          end
        end else begin
          scan_x_d = scan_x_q + 9'd1;
        end
      end
      // Hold off DONE until the final issued pixel has left the delay line and plotted.
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d   = 3'd0;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        scan_x_d    = 9'd0;
        scan_y_d    = 9'd0;
        drain_cnt_d = 3'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_comb begin
    dly_vld_d    = dly_vld_q;
    dly_x_d      = dly_x_q;
    dly_y_d      = dly_y_q;
    dly_vld_d[0] = issue_s;
    dly_x_d[0]   = scan_x_q;
    dly_y_d[0]   = scan_y_q;
    for (int i = 1; i < LOOKUP_LAT; i++) begin
      dly_vld_d[i] = dly_vld_q[i-1];
      dly_x_d[i]   = dly_x_q[i-1];
      dly_y_d[i]   = dly_y_q[i-1];
    end
  end

  always_comb begin
`ifdef SKIP_BLACK_EN
    keep_s = (flag_in != 3'b000);
`else
    keep_s = 1'b1;
`endif
    plot_d       = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (tap_vld_s && keep_s) begin
      plot_d       = 1'b1;
      vga_x_d      = tap_x_s;
      vga_y_d      = tap_y_s;
      vga_colour_d = flag_in;
    end else begin
      plot_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      scan_x_q      <= 9'd0;
      scan_y_q      <= 9'd0;
      drain_cnt_q   <= 3'd0;
      frame_count_q <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      plot_q        <= 1'b0;
      vga_x_q       <= 9'd0;
      vga_y_q       <= 9'd0;
      vga_colour_q  <= 3'd0;
      dly_vld_q     <= '0;
      dly_x_q       <= '0;
      dly_y_q       <= '0;
    end else begin
      state_q       <= state_d;
      scan_x_q      <= scan_x_d;
      scan_y_q      <= scan_y_d;
      drain_cnt_q   <= drain_cnt_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      plot_q        <= plot_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      dly_vld_q     <= dly_vld_d;
      dly_x_q       <= dly_x_d;
      dly_y_q       <= dly_y_d;
    end
  end

  assign scan_x      = scan_x_q;
  assign scan_y      = scan_y_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign plot        = plot_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule
